// File: rtl/cia_bus_cycle_pkg.sv
// Shared types and defaults for the CIA E-clock host handshake.
// State encodings are visible to the U409 top for debug.
package cia_bus_cycle_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CLR = 3'd1,
    REQ      = 3'd2,
    E_HIGH   = 3'd3,
    ACK      = 3'd4,
    RECOVER  = 3'd5
  } cia_state_e;

  localparam int RD_LATCH_DLY_DEF = 20;
  localparam int TIMEOUT_DEF      = 1023;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cia_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses.
// Pulses line up with the cycle the synchronised value changes.
module cia_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= d;
      q    <= s1;
      rise <= s1 & ~q;
      fall <= ~s1 & q;
    end
  end

endmodule

// File: rtl/cia_bus_cycle.sv
// Host-side CIA bus cycle: claims one E period from the CLK7
// generator, strobes read data and ends with TA_n or TEA_n.
module cia_bus_cycle
  import cia_bus_cycle_pkg::*;
#(
  parameter int RD_LATCH_DLY = RD_LATCH_DLY_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic CLK40,
  input  logic nRESET,
  input  logic TS_n,
  input  logic CIA_SEL,
  input  logic RnW,
  input  logic CLKCIA,
  input  logic CIA_ENABLE,
  output logic CIA_SPACE,
  output logic CIA_LATCH,
  output logic CIA_DOE,
  output logic TA_n,
  output logic TEA_n,
  output logic CIA_BUSY
);

  localparam int TW = cnt_w(TIMEOUT);
  localparam int DW = cnt_w(RD_LATCH_DLY);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DLY_LOAD = DW'(RD_LATCH_DLY);

  cia_state_e    state;
  logic          rnw_q;
  logic [TW-1:0] tmo;
  logic [DW-1:0] dly;
  logic          armed;
  logic          latched;

  logic e_s, e_rise, e_fall;
  logic en_s, en_rise_unused, en_fall_unused;

  cia_sync_edge u_e_sync (
    .clk  (CLK40),
    .rst_n(nRESET),
    .d    (CLKCIA),
    .q    (e_s),
    .rise (e_rise),
    .fall (e_fall)
  );

  cia_sync_edge u_en_sync (
    .clk  (CLK40),
    .rst_n(nRESET),
    .d    (CIA_ENABLE),
    .q    (en_s),
    .rise (en_rise_unused),
    .fall (en_fall_unused)
  );

  always_ff @(posedge CLK40) begin
    if (!nRESET) begin
      state     <= IDLE;
      rnw_q     <= 1'b1;
      tmo       <= '0;
      dly       <= '0;
      armed     <= 1'b0;
      latched   <= 1'b0;
      CIA_SPACE <= 1'b0;
      CIA_LATCH <= 1'b0;
      CIA_DOE   <= 1'b0;
      TA_n      <= 1'b1;
      TEA_n     <= 1'b1;
      CIA_BUSY  <= 1'b0;
    end else begin
      CIA_LATCH <= 1'b0;
      TA_n      <= 1'b1;
      TEA_n     <= 1'b1;
      if (state != IDLE)
        tmo <= tmo + TW'(1);
      // Timeout overrides every state action, including TA_n
      if (state != IDLE && tmo == TMO_LAST) begin
        state     <= IDLE;
        TEA_n     <= 1'b0;
        CIA_SPACE <= 1'b0;
        CIA_DOE   <= 1'b0;
        CIA_BUSY  <= 1'b0;
        armed     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!TS_n && CIA_SEL) begin
              rnw_q    <= RnW;
              tmo      <= '0;
              armed    <= 1'b0;
              latched  <= 1'b0;
              CIA_BUSY <= 1'b1;
              if (en_s) begin
                state <= WAIT_CLR;
              end else begin
                state     <= REQ;
                CIA_SPACE <= 1'b1;
              end
            end
          end
          WAIT_CLR: begin
            if (!en_s) begin
              state     <= REQ;
              CIA_SPACE <= 1'b1;
            end
          end
          REQ: begin
            if (en_s) begin
              state     <= E_HIGH;
              CIA_SPACE <= 1'b0;
              CIA_DOE   <= ~rnw_q;
            end
          end
          E_HIGH: begin
            // A short E still gets its single latch on the fall
            if (e_fall) begin
              state <= ACK;
              TA_n  <= 1'b0;
              armed <= 1'b0;
              if (rnw_q && !latched) begin
                CIA_LATCH <= 1'b1;
                latched   <= 1'b1;
              end
            end else if (e_rise) begin
              dly   <= DLY_LOAD;
              armed <= 1'b1;
            end else if (armed) begin
              if (dly == '0) begin
                armed <= 1'b0;
                if (rnw_q && !latched) begin
                  CIA_LATCH <= 1'b1;
                  latched   <= 1'b1;
                end
              end else begin
                dly <= dly - DW'(1);
              end
            end
          end
          ACK: begin
            state   <= RECOVER;
            CIA_DOE <= 1'b0;
          end
          RECOVER: begin
            if (!en_s) begin
              state    <= IDLE;
              CIA_BUSY <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
